// File: rtl/h264_recon_mbwrite_if.sv
// Bus between the reconstruct stage, the MB write block and the MB buffer consumer.
// The slave modport is the write block itself; the master modport is its environment.
interface h264_recon_mbwrite_if;
  logic        NEWSLICE;
  logic        STROBEI;
  logic        CSTROBEI;
  logic [31:0] DATAI;
  logic        WE;
  logic [7:0]  WADDR;
  logic [31:0] WDATA;
  logic        MBVALID;
  logic        RDBANK;
  logic        MBACK;
  logic        READY;
  logic [15:0] MBSUM;
  logic        ERR_OVF;
  logic        ERR_PROTO;

  modport slave (
    input  NEWSLICE, STROBEI, CSTROBEI, DATAI, MBACK,
    output WE, WADDR, WDATA, MBVALID, RDBANK, READY, MBSUM, ERR_OVF, ERR_PROTO
  );

  modport master (
    output NEWSLICE, STROBEI, CSTROBEI, DATAI, MBACK,
    input  WE, WADDR, WDATA, MBVALID, RDBANK, READY, MBSUM, ERR_OVF, ERR_PROTO
  );
endinterface

// File: rtl/h264_recon_mbwrite.sv
// Writes reconstructed luma/chroma words of one MB into a two-bank MB buffer.
// Optional per-bank pixel checksum on MBSUM when H264_MBWRITE_CHECKSUM_EN is defined.
module h264_recon_mbwrite (
  input  logic                    CLK2,
  input  logic                    RSTN,
  h264_recon_mbwrite_if.slave     bus
);

  typedef enum logic [1:0] {ST_WAIT, ST_LUMA, ST_CHROMA} state_t;

  state_t      state, state_nxt;
  logic        fill_bank, fill_bank_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [1:0]  busy, busy_nxt, busy_ack;
  logic [1:0]  full, full_nxt, ack_mask;
  logic        rd_bank, rd_bank_nxt;
  logic        accept, last_word, set_ovf, set_proto, start_fill;
  logic [6:0]  offset;
  logic        done_p1, done_bank_p1;
  logic        vld_p1;
  logic [7:0]  waddr_p1;
  logic [31:0] wdata_p1;
  logic        err_ovf, err_proto;

  // busy marks a bank that is complete or waiting to become complete;
  // the bank being filled is tracked separately by state/fill_bank.
  always_comb begin
    ack_mask      = (bus.MBACK && full[rd_bank]) ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    busy_ack      = busy & ~ack_mask;
    busy_nxt      = busy_ack;
    state_nxt     = state;
    fill_bank_nxt = fill_bank;
    cnt_nxt       = cnt;
    accept        = 1'b0;
    last_word     = 1'b0;
    set_ovf       = 1'b0;
    set_proto     = 1'b0;
    start_fill    = 1'b0;
    offset        = (state == ST_CHROMA) ? {2'b10, cnt[4], cnt[3], cnt[1:0], cnt[2]}
                                         : {1'b0, cnt[5], cnt[3], cnt[1:0], cnt[4], cnt[2]};
    if (bus.NEWSLICE) begin
      cnt_nxt = 6'd0;
      if (state != ST_WAIT) begin
        state_nxt  = ST_LUMA;
        start_fill = 1'b1;
      end else if (busy_ack != 2'b11) begin
        state_nxt     = ST_LUMA;
        fill_bank_nxt = busy_ack[0];
        start_fill    = 1'b1;
      end
    end else begin
      unique case (state)
        ST_WAIT: begin
          set_ovf   = bus.STROBEI | bus.CSTROBEI;
          set_proto = bus.STROBEI & bus.CSTROBEI;
          if (busy_ack != 2'b11) begin
            state_nxt     = ST_LUMA;
            fill_bank_nxt = busy_ack[0];
            start_fill    = 1'b1;
          end
        end
        ST_LUMA: begin
          if (bus.CSTROBEI) begin
            set_proto = 1'b1;
          end else if (bus.STROBEI) begin
            accept  = 1'b1;
            cnt_nxt = cnt + 6'd1;
            if (cnt == 6'd63) state_nxt = ST_CHROMA;
          end
        end
        ST_CHROMA: begin
          if (bus.STROBEI) begin
            set_proto = 1'b1;
          end else if (bus.CSTROBEI) begin
            accept  = 1'b1;
            cnt_nxt = cnt + 6'd1;
            if (cnt == 6'd31) begin
              last_word           = 1'b1;
              cnt_nxt             = 6'd0;
              busy_nxt[fill_bank] = 1'b1;
              if (!busy_ack[~fill_bank]) begin
                state_nxt     = ST_LUMA;
                fill_bank_nxt = ~fill_bank;
                start_fill    = 1'b1;
              end else begin
                state_nxt = ST_WAIT;
              end
            end
          end
        end
        default: state_nxt = ST_LUMA;
      endcase
    end
    // Oldest-first: keep rd_bank while it still holds a complete MB.
    full_nxt    = (full & ~ack_mask) |
                  (done_p1 ? (done_bank_p1 ? 2'b10 : 2'b01) : 2'b00);
    rd_bank_nxt = (!full_nxt[rd_bank] && full_nxt[~rd_bank]) ? ~rd_bank : rd_bank;
  end

  always_ff @(posedge CLK2 or negedge RSTN) begin
    if (!RSTN) begin
      state        <= ST_LUMA;
      fill_bank    <= 1'b0;
      cnt          <= 6'd0;
      busy         <= 2'b00;
      full         <= 2'b00;
      rd_bank      <= 1'b0;
      err_ovf      <= 1'b0;
      err_proto    <= 1'b0;
      done_p1      <= 1'b0;
      done_bank_p1 <= 1'b0;
      vld_p1       <= 1'b0;
      waddr_p1     <= 8'h00;
      wdata_p1     <= 32'h0;
    end else begin
      state        <= state_nxt;
      fill_bank    <= fill_bank_nxt;
      cnt          <= cnt_nxt;
      busy         <= busy_nxt;
      full         <= full_nxt;
      rd_bank      <= rd_bank_nxt;
      err_ovf      <= err_ovf | set_ovf;
      err_proto    <= err_proto | set_proto;
      // ---- stage p1: buffer write, completion pending ----
      done_p1      <= last_word;
      done_bank_p1 <= fill_bank;
      vld_p1       <= accept;
      if (accept) begin
        waddr_p1 <= {fill_bank, offset};
        wdata_p1 <= bus.DATAI;
      end
    end
  end

`ifdef H264_MBWRITE_CHECKSUM_EN
  logic [15:0] sum_p1 [2];

  function automatic logic [15:0] byte_sum(input logic [31:0] w);
    return {8'h00, w[7:0]} + {8'h00, w[15:8]} + {8'h00, w[23:16]} + {8'h00, w[31:24]};
  endfunction

  always_ff @(posedge CLK2 or negedge RSTN) begin
    if (!RSTN) begin
      sum_p1[0] <= 16'h0;
      sum_p1[1] <= 16'h0;
    end else begin
      if (start_fill) sum_p1[fill_bank_nxt] <= 16'h0;
      if (accept)     sum_p1[fill_bank]     <= sum_p1[fill_bank] + byte_sum(bus.DATAI);
    end
  end

  assign bus.MBSUM = full[rd_bank] ? sum_p1[rd_bank] : 16'h0;
`else
  assign bus.MBSUM = 16'h0;
`endif

  assign bus.WE        = vld_p1;
  assign bus.WADDR     = waddr_p1;
  assign bus.WDATA     = wdata_p1;
  assign bus.MBVALID   = full[rd_bank];
  assign bus.RDBANK    = rd_bank;
  assign bus.READY     = (state != ST_WAIT);
  assign bus.ERR_OVF   = err_ovf;
  assign bus.ERR_PROTO = err_proto;

endmodule

// File: tb/tb_h264_recon_mbwrite.sv
// Scoreboard bench for h264_recon_mbwrite: expected buffer writes are queued by the
// stimulus and popped by a monitor on every WE; status outputs are checked directly.
module tb_h264_recon_mbwrite;
  logic CLK2 = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK2 = ~CLK2;

  h264_recon_mbwrite_if bus();

  h264_recon_mbwrite dut (
    .CLK2 (CLK2),
    .RSTN (RSTN),
    .bus  (bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  obs_log[$];
  logic [15:0] acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every buffer write must match the oldest outstanding expectation.
  always @(negedge CLK2) begin
    if (RSTN && bus.WE === 1'b1) begin
      logic [39:0] e;
      vectors++;
      obs_log.push_back(bus.WADDR);
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                 bus.WADDR, bus.WDATA);
      end else begin
        e = exp_q.pop_front();
        if ({bus.WADDR, bus.WDATA} !== e) begin
          miscompares++;
          $display("FAIL write: got addr 0x%0h data 0x%0h, want addr 0x%0h data 0x%0h",
                   bus.WADDR, bus.WDATA, e[39:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [6:0] luma_off(input int n);
    int blk, row, col;
    blk = n / 4;
    row = 8 * ((blk >> 3) & 1) + 4 * ((blk >> 1) & 1) + (n % 4);
    col = 2 * ((blk >> 2) & 1) + (blk & 1);
    return 7'(4 * row + col);
  endfunction

  function automatic logic [6:0] chroma_off(input int m);
    int blk, row;
    blk = (m >> 2) & 3;
    row = 4 * ((blk >> 1) & 1) + (m % 4);
    return 7'(64 + 16 * ((m >> 4) & 1) + 2 * row + (blk & 1));
  endfunction

  function automatic logic [31:0] word_of(input int k, input int pat);
    logic [7:0] b;
    b = (pat < 0) ? k[7:0] : pat[7:0];
    return {b, b, b, b};
  endfunction

  function automatic logic [15:0] sum_exp(input logic [15:0] v);
`ifdef H264_MBWRITE_CHECKSUM_EN
    return v;
`else
    return (v & 16'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge CLK2);
    #1;
  endtask

  task automatic put(input logic l, input logic c, input logic ns, input logic ack,
                     input logic [31:0] d, input logic exp_we, input logic [7:0] addr);
    bus.STROBEI  = l;
    bus.CSTROBEI = c;
    bus.NEWSLICE = ns;
    bus.MBACK    = ack;
    bus.DATAI    = d;
    if (exp_we) exp_q.push_back({addr, d});
    tick();
    bus.STROBEI  = 1'b0;
    bus.CSTROBEI = 1'b0;
    bus.NEWSLICE = 1'b0;
    bus.MBACK    = 1'b0;
  endtask

  task automatic send_words(input logic bank, input int first, input int last,
                            input int pat, input logic ack_last);
    for (int k = first; k <= last; k++) begin
      logic [31:0] d;
      logic [7:0]  a;
      d   = word_of(k, pat);
      a   = (k < 64) ? {bank, luma_off(k)} : {bank, chroma_off(k - 64)};
      acc = acc + d[7:0] + d[15:8] + d[23:16] + d[31:24];
      put(k < 64, k >= 64, 1'b0, ack_last && (k == last), d, 1'b1, a);
    end
  endtask

  task automatic pulse_ack();
    put(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00);
  endtask

  function automatic logic [7:0] obs_at(input int i);
    return (i < obs_log.size()) ? obs_log[i] : 8'hEE;
  endfunction

  initial begin
    bus.NEWSLICE = 1'b0;
    bus.STROBEI  = 1'b0;
    bus.CSTROBEI = 1'b0;
    bus.MBACK    = 1'b0;
    bus.DATAI    = 32'h0;
    acc          = 16'h0;

    // Reset values
    repeat (2) @(posedge CLK2);
    #1;
    chk("rst_we", bus.WE, 1'b0);
    chk("rst_waddr", bus.WADDR, 8'h00);
    chk("rst_wdata", bus.WDATA, 32'h0);
    chk("rst_mbvalid", bus.MBVALID, 1'b0);
    chk("rst_rdbank", bus.RDBANK, 1'b0);
    chk("rst_mbsum", bus.MBSUM, 16'h0);
    chk("rst_err_ovf", bus.ERR_OVF, 1'b0);
    chk("rst_err_proto", bus.ERR_PROTO, 1'b0);
    @(negedge CLK2);
    RSTN = 1'b1;
    #1;
    chk("rst_ready", bus.READY, 1'b1);
    tick();

    // MB 1 into bank 0, word k = {4{k}}
    obs_log.delete();
    acc = 16'h0;
    send_words(1'b0, 0, 95, -1, 1'b0);
    tick();
    chk("mb1_addr_l4", obs_at(4), 8'h01);
    chk("mb1_addr_l16", obs_at(16), 8'h02);
    chk("mb1_addr_l32", obs_at(32), 8'h20);
    chk("mb1_addr_c20", obs_at(84), 8'h51);
    chk("mb1_mbvalid", bus.MBVALID, 1'b1);
    chk("mb1_rdbank", bus.RDBANK, 1'b0);
    chk("mb1_mbsum", bus.MBSUM, sum_exp(acc));
    chk("mb1_ready", bus.READY, 1'b1);

    // MB 2 into bank 1 without consuming, then an overflow strobe
    acc = 16'h0;
    send_words(1'b1, 0, 95, 8'h01, 1'b0);
    tick();
    chk("mb2_ready", bus.READY, 1'b0);
    chk("mb2_rdbank", bus.RDBANK, 1'b0);
    put(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 8'h00);
    chk("ovf_flag", bus.ERR_OVF, 1'b1);
    chk("ovf_no_proto", bus.ERR_PROTO, 1'b0);

    // Consume bank 0 -> bank 1 becomes current, filling resumes in bank 0
    pulse_ack();
    chk("ack1_rdbank", bus.RDBANK, 1'b1);
    chk("ack1_mbvalid", bus.MBVALID, 1'b1);
    chk("ack1_mbsum", bus.MBSUM, sum_exp(16'h0180));
    chk("ack1_ready", bus.READY, 1'b1);
    pulse_ack();
    chk("ack2_mbvalid", bus.MBVALID, 1'b0);
    chk("ack2_mbsum", bus.MBSUM, 16'h0);

    // NEWSLICE after 10 luma words; the strobe alongside it is dropped
    send_words(1'b0, 0, 9, -1, 1'b0);
    put(1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 8'h00);
    chk("ns_mbvalid", bus.MBVALID, 1'b0);
    chk("ns_ready", bus.READY, 1'b1);
    acc = 16'h0;
    send_words(1'b0, 0, 94, 8'hFF, 1'b0);
    tick();
    chk("ns_no_early_valid", bus.MBVALID, 1'b0);
    send_words(1'b0, 95, 95, 8'hFF, 1'b0);
    tick();
    chk("ns_mbvalid_done", bus.MBVALID, 1'b1);
    chk("ns_rdbank", bus.RDBANK, 1'b0);
    chk("ns_mbsum_ff", bus.MBSUM, sum_exp(16'h7E80));
    chk("ns_ovf_sticky", bus.ERR_OVF, 1'b1);
    pulse_ack();

    // Protocol errors in bank 1 during luma word 5
    send_words(1'b1, 0, 4, -1, 1'b0);
    put(1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b0, 8'h00);
    chk("proto_flag", bus.ERR_PROTO, 1'b1);
    put(1'b1, 1'b1, 1'b0, 1'b0, 32'h55555555, 1'b0, 8'h00);
    obs_log.delete();
    send_words(1'b1, 5, 95, -1, 1'b0);
    tick();
    chk("proto_word5_addr", obs_at(0), {1'b1, 7'h05});
    chk("proto_mbvalid", bus.MBVALID, 1'b1);
    chk("proto_rdbank", bus.RDBANK, 1'b1);

    // MBACK together with the final chroma word of the next MB (bank 0)
    acc = 16'h0;
    send_words(1'b0, 0, 95, 8'h01, 1'b1);
    chk("same_cyc_freed", bus.MBVALID, 1'b0);
    chk("same_cyc_ready", bus.READY, 1'b1);
    tick();
    chk("same_cyc_mbvalid", bus.MBVALID, 1'b1);
    chk("same_cyc_rdbank", bus.RDBANK, 1'b0);
    chk("same_cyc_mbsum", bus.MBSUM, sum_exp(16'h0180));
    pulse_ack();
    pulse_ack();
    chk("ack_idle_mbvalid", bus.MBVALID, 1'b0);
    chk("ack_idle_ready", bus.READY, 1'b1);

    // Asynchronous reset mid-CHROMA, between clock edges
    send_words(1'b1, 0, 69, -1, 1'b0);
    #2;
    RSTN = 1'b0;
    #1;
    chk("arst_we", bus.WE, 1'b0);
    chk("arst_waddr", bus.WADDR, 8'h00);
    chk("arst_wdata", bus.WDATA, 32'h0);
    chk("arst_mbvalid", bus.MBVALID, 1'b0);
    chk("arst_rdbank", bus.RDBANK, 1'b0);
    chk("arst_mbsum", bus.MBSUM, 16'h0);
    chk("arst_err_ovf", bus.ERR_OVF, 1'b0);
    chk("arst_err_proto", bus.ERR_PROTO, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge CLK2);
    @(negedge CLK2);
    RSTN = 1'b1;
    #1;
    chk("arst_ready", bus.READY, 1'b1);
    tick();
    obs_log.delete();
    send_words(1'b0, 0, 0, -1, 1'b0);
    tick();
    chk("arst_first_addr", obs_at(0), 8'h00);

    // Drain outstanding expectations with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    chk("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
